arf_sequencer: RTL and testbench

//  Micro-sequencer for the address register file (PC, AR, SP). Accepts one op at a time

---
 rtl/arf_ctrl_pkg.sv | 38 +++
 rtl/arf_stack_guard.sv | 42 ++++
 rtl/arf_sequencer.sv | 155 +++++++++++++++
 tb/tb_arf_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arf_ctrl_pkg.sv
// Shared encodings for the address register file micro-sequencer:
// op codes, ARF control codes and FSM state constants.
package arf_ctrl_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_FETCH = 3'b001;
    localparam logic [2:0] OP_PUSH  = 3'b010;
    localparam logic [2:0] OP_POP   = 3'b011;
    localparam logic [2:0] OP_JUMP  = 3'b100;
    localparam logic [2:0] OP_LDAR  = 3'b101;
    localparam logic [2:0] OP_CLR   = 3'b110;
    localparam logic [2:0] OP_ILL   = 3'b111;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;

    // RegSel is active low: a cleared bit enables that register
    localparam logic [2:0] RS_PC   = 3'b011;
    localparam logic [2:0] RS_AR   = 3'b101;
    localparam logic [2:0] RS_SP   = 3'b110;
    localparam logic [2:0] RS_ALL  = 3'b000;
    localparam logic [2:0] RS_NONE = 3'b111;

    localparam logic [1:0] SEL_PC = 2'b00;
    localparam logic [1:0] SEL_AR = 2'b10;
    localparam logic [1:0] SEL_SP = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_X1   = 2'b01;
    localparam logic [1:0] ST_X2   = 2'b10;

    function automatic logic is_two_cycle(input logic [2:0] op);
        return (op == OP_FETCH) || (op == OP_PUSH) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/arf_stack_guard.sv
// Stack depth tracker for the ARF sequencer; only built when
// ARF_STACK_GUARD_EN is defined.
module arf_stack_guard #(
    parameter int STACK_DEPTH = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full,
    output logic empty
);

    localparam int W = $clog2(STACK_DEPTH + 1);

    logic [W-1:0] depth_q;
    logic [W-1:0] depth_d;

    assign full  = (depth_q == W'(STACK_DEPTH));
    assign empty = (depth_q == '0);

    always_comb begin
        depth_d = depth_q;
        if (clr) begin
            depth_d = '0;
        end else if (inc && !full) begin
            depth_d = depth_q + W'(1);
        end else if (dec && !empty) begin
            depth_d = depth_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/arf_sequencer.sv
// Micro-sequencer driving the PC/AR/SP register file controls.
// Define ARF_STACK_GUARD_EN to reject stack overflow/underflow.
module arf_sequencer
    import arf_ctrl_pkg::*;
#(
    parameter int STACK_DEPTH = 256
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Req_Valid,
    input  logic [2:0] Req_Op,
    output logic       Req_Ready,
    output logic [2:0] FunSel,
    output logic [2:0] RegSel,
    output logic [1:0] OutCSel,
    output logic [1:0] OutDSel,
    output logic       MemRd,
    output logic       MemWr,
    output logic [1:0] IRWr,
    output logic       Done,
    output logic       Err
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] op_q;
    logic [2:0] op_d;
    logic       rej;

`ifdef ARF_STACK_GUARD_EN
    logic full;
    logic empty;

    arf_stack_guard #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_guard (
        .clk  (Clock),
        .rst_n(Reset_n),
        .inc  (state_q == ST_X2 && op_q == OP_PUSH),
        .dec  (state_q == ST_X2 && op_q == OP_POP),
        .clr  (state_q == ST_X1 && op_q == OP_CLR),
        .full (full),
        .empty(empty)
    );

    assign rej = (op_q == OP_ILL)
               || (op_q == OP_PUSH && full)
               || (op_q == OP_POP && empty);
`else
    localparam int unused_depth = STACK_DEPTH;

    assign rej = (op_q == OP_ILL);
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Req_Valid) begin
                    state_d = ST_X1;
                    op_d    = Req_Op;
                end
            end
            ST_X1: begin
                if (is_two_cycle(op_q) && !rej) begin
                    state_d = ST_X2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        Req_Ready = (state_q == ST_IDLE);
        FunSel    = FS_DEC;
        RegSel    = RS_NONE;
        OutCSel   = SEL_PC;
        OutDSel   = SEL_PC;
        MemRd     = 1'b0;
        MemWr     = 1'b0;
        IRWr      = 2'b00;
        Done      = 1'b0;
        Err       = 1'b0;
        if (state_q == ST_X1) begin
            if (rej) begin
                Done = 1'b1;
                Err  = 1'b1;
            end else begin
                Done = !is_two_cycle(op_q);
                unique case (op_q)
                    OP_FETCH: begin
                        MemRd  = 1'b1;
                        IRWr   = 2'b01;
                        FunSel = FS_INC;
                        RegSel = RS_PC;
                    end
                    OP_PUSH: begin
                        FunSel = FS_DEC;
                        RegSel = RS_SP;
                    end
                    OP_POP: begin
                        OutDSel = SEL_SP;
                        MemRd   = 1'b1;
                    end
                    OP_JUMP: begin
                        FunSel = FS_LOAD;
                        RegSel = RS_PC;
                    end
                    OP_LDAR: begin
                        FunSel = FS_LOAD;
                        RegSel = RS_AR;
                    end
                    OP_CLR: begin
                        FunSel = FS_CLR;
                        RegSel = RS_ALL;
                    end
                    default: ;
                endcase
            end
        end else if (state_q == ST_X2) begin
            Done = 1'b1;
            unique case (op_q)
                OP_FETCH: begin
                    MemRd  = 1'b1;
                    IRWr   = 2'b10;
                    FunSel = FS_INC;
                    RegSel = RS_PC;
                end
                OP_PUSH: begin
                    OutDSel = SEL_SP;
                    MemWr   = 1'b1;
                end
                OP_POP: begin
                    FunSel = FS_INC;
                    RegSel = RS_SP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arf_sequencer.sv
// Directed bench for arf_sequencer with a behavioural PC/AR/SP model.
// Expectations follow ARF_STACK_GUARD_EN when it is defined.
module tb_arf_sequencer;

    logic       Clock;
    logic       Reset_n;
    logic       Req_Valid;
    logic [2:0] Req_Op;
    logic       Req_Ready;
    logic [2:0] FunSel;
    logic [2:0] RegSel;
    logic [1:0] OutCSel;
    logic [1:0] OutDSel;
    logic       MemRd;
    logic       MemWr;
    logic [1:0] IRWr;
    logic       Done;
    logic       Err;

    int checks = 0;
    int failures = 0;

    logic [15:0] i_bus;
    logic        preload;
    logic [15:0] pre_pc, pre_ar, pre_sp;
    logic [15:0] pc_m, ar_m, sp_m;
    logic [16:0] dut_v;

    arf_sequencer #(
        .STACK_DEPTH(2)
    ) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Req_Valid(Req_Valid),
        .Req_Op   (Req_Op),
        .Req_Ready(Req_Ready),
        .FunSel   (FunSel),
        .RegSel   (RegSel),
        .OutCSel  (OutCSel),
        .OutDSel  (OutDSel),
        .MemRd    (MemRd),
        .MemWr    (MemWr),
        .IRWr     (IRWr),
        .Done     (Done),
        .Err      (Err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    assign dut_v = {Req_Ready, FunSel, RegSel, OutCSel, OutDSel,
                    MemRd, MemWr, IRWr, Done, Err};

    function automatic logic [15:0] arf_fn(input logic [2:0] fs,
                                           input logic [15:0] v,
                                           input logic [15:0] i);
        case (fs)
            3'b000:  return v - 16'd1;
            3'b001:  return v + 16'd1;
            3'b010:  return i;
            3'b011:  return 16'd0;
            default: return v;
        endcase
    endfunction

    // Register file model: acts on the controls present at each edge
    always @(posedge Clock) begin
        if (preload) begin
            pc_m <= pre_pc;
            ar_m <= pre_ar;
            sp_m <= pre_sp;
        end else begin
            if (!RegSel[2]) pc_m <= arf_fn(FunSel, pc_m, i_bus);
            if (!RegSel[1]) ar_m <= arf_fn(FunSel, ar_m, i_bus);
            if (!RegSel[0]) sp_m <= arf_fn(FunSel, sp_m, i_bus);
        end
    end

    function automatic logic [16:0] ov(
        input logic rdy, input logic [2:0] fs, input logic [2:0] rs,
        input logic [1:0] oc, input logic [1:0] od, input logic rd,
        input logic wr, input logic [1:0] ir, input logic dn,
        input logic er);
        return {rdy, fs, rs, oc, od, rd, wr, ir, dn, er};
    endfunction

    task automatic chk(input string tag, input logic [16:0] got,
                       input logic [16:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic hold);
        Req_Valid = 1'b1;
        Req_Op    = op;
        step();
        Req_Valid = hold;
    endtask

    task automatic run_push(input string tag, input logic exp_err,
                            input logic [15:0] exp_sp);
        issue(3'b010, 1'b0);
        chk({tag, "_err"}, 17'(Err), 17'(exp_err));
        if (exp_err) begin
            step();
        end else begin
            step();
            step();
        end
        chk({tag, "_sp"}, 17'(sp_m), 17'(exp_sp));
    endtask

    localparam logic [16:0] IDLE_V = 17'b1_000_111_00_00_0_0_00_0_0;

    initial begin
        Reset_n   = 1'b0;
        Req_Valid = 1'b0;
        Req_Op    = 3'b000;
        i_bus     = 16'h0000;
        preload   = 1'b0;
        pre_pc    = 16'h0010;
        pre_ar    = 16'h0000;
        pre_sp    = 16'h00FF;
        #11;
        chk("reset_idle", dut_v, IDLE_V);
        Reset_n = 1'b1;
        preload = 1'b1;
        step();
        preload = 1'b0;
        chk("post_reset_idle", dut_v, IDLE_V);

        // FETCH with Req_Valid held through the sequence
        issue(3'b001, 1'b1);
        chk("fetch_x1", dut_v, ov(0, 3'b001, 3'b011, 0, 0, 1, 0, 2'b01, 0, 0));
        step();
        chk("fetch_pc1", 17'(pc_m), 17'h0011);
        chk("fetch_x2", dut_v, ov(0, 3'b001, 3'b011, 0, 0, 1, 0, 2'b10, 1, 0));
        step();
        chk("fetch_no_reaccept", dut_v, IDLE_V);
        chk("fetch_pc2", 17'(pc_m), 17'h0012);
        Req_Valid = 1'b0;
        step();

        issue(3'b010, 1'b0);
        chk("push_x1", dut_v, ov(0, 3'b000, 3'b110, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk("push_sp", 17'(sp_m), 17'h00FE);
        chk("push_x2", dut_v, ov(0, 3'b000, 3'b111, 0, 2'b11, 0, 1, 0, 1, 0));
        step();
        chk("push_idle", dut_v, IDLE_V);

        issue(3'b011, 1'b0);
        chk("pop_x1", dut_v, ov(0, 3'b000, 3'b111, 0, 2'b11, 1, 0, 0, 0, 0));
        chk("pop_addr_sp", 17'(sp_m), 17'h00FE);
        step();
        chk("pop_x2", dut_v, ov(0, 3'b001, 3'b110, 0, 0, 0, 0, 0, 1, 0));
        step();
        chk("pop_sp", 17'(sp_m), 17'h00FF);

        i_bus = 16'h1234;
        issue(3'b100, 1'b0);
        chk("jump_x1", dut_v, ov(0, 3'b010, 3'b011, 0, 0, 0, 0, 0, 1, 0));
        step();
        chk("jump_pc", 17'(pc_m), 17'h1234);
        chk("jump_idle", dut_v, IDLE_V);

        i_bus = 16'hBEEF;
        issue(3'b101, 1'b0);
        chk("ldar_x1", dut_v, ov(0, 3'b010, 3'b101, 0, 0, 0, 0, 0, 1, 0));
        step();
        chk("ldar_ar", 17'(ar_m), 17'hBEEF);
        chk("ldar_pc", 17'(pc_m), 17'h1234);

        // Illegal op with Req_Valid held: exactly one X1 cycle
        issue(3'b111, 1'b1);
        chk("ill_x1", dut_v, ov(0, 3'b000, 3'b111, 0, 0, 0, 0, 0, 1, 1));
        step();
        chk("ill_idle", dut_v, IDLE_V);
        Req_Valid = 1'b0;
        chk("ill_regs", 17'({pc_m ^ ar_m ^ sp_m}), 17'(16'h1234 ^ 16'hBEEF ^ 16'h00FF));

        issue(3'b000, 1'b0);
        chk("nop_x1", dut_v, ov(0, 3'b000, 3'b111, 0, 0, 0, 0, 0, 1, 0));
        step();
        chk("nop_idle", dut_v, IDLE_V);

        issue(3'b110, 1'b0);
        chk("clr_x1", dut_v, ov(0, 3'b011, 3'b000, 0, 0, 0, 0, 0, 1, 0));
        step();
        chk("clr_regs", 17'(pc_m | ar_m | sp_m), 17'h0);

`ifdef ARF_STACK_GUARD_EN
        issue(3'b011, 1'b0);
        chk("pop_empty", dut_v, ov(0, 3'b000, 3'b111, 0, 0, 0, 0, 0, 1, 1));
        step();
        chk("pop_empty_sp", 17'(sp_m), 17'h0000);
        run_push("push1", 1'b0, 16'hFFFF);
        run_push("push2", 1'b0, 16'hFFFE);
        run_push("push3", 1'b1, 16'hFFFE);
`else
        issue(3'b011, 1'b0);
        chk("pop_empty", dut_v, ov(0, 3'b000, 3'b111, 0, 2'b11, 1, 0, 0, 0, 0));
        step();
        step();
        chk("pop_empty_sp", 17'(sp_m), 17'h0001);
        run_push("push1", 1'b0, 16'h0000);
        run_push("push2", 1'b0, 16'hFFFF);
        run_push("push3", 1'b0, 16'hFFFE);
`endif
        chk("guard_idle", dut_v, IDLE_V);

        // Asynchronous reset in the middle of FETCH X1
        issue(3'b001, 1'b0);
        chk("rst_fetch_x1", 17'(MemRd), 17'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_async_idle", dut_v, IDLE_V);
        @(posedge Clock);
        #2;
        Reset_n = 1'b1;
        step();
        chk("rst_release_idle", dut_v, IDLE_V);
        chk("rst_pc_at_most_1", 17'(pc_m <= 16'h0001), 17'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
